// File: rtl/uart_rx_frame_ctrl_pkg.sv
// Shared types and helpers for the UART receive frame controller.
package uart_frame_pkg;

  // Frame parser states, 3-bit binary encoded.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN     = 3'd1,
    PAYLOAD = 3'd2,
    CKSUM   = 3'd3,
    DRAIN   = 3'd4
  } frame_state_t;

  // Default start-of-frame marker.
  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  // Running frame checksum: plain 8-bit XOR accumulation.
  function automatic logic [7:0] cksum_next(input logic [7:0] cur, input logic [7:0] data_byte);
    return cur ^ data_byte;
  endfunction

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// Byte-strobe input, valid/ready payload stream and error pulses of the frame controller.
interface uart_rx_frame_ctrl_if #(
  parameter int LEN_W = 5
) ();

  logic [7:0]       rx_data;
  logic             done_flag;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic             out_last;
  logic [LEN_W-1:0] frm_len;
  logic             busy;
  logic             err_len;
  logic             err_cksum;
  logic             err_tmo;
  logic             err_ovr;

  // Upstream byte source and downstream consumer side.
  modport master (
    output rx_data, done_flag, out_ready,
    input  out_valid, out_data, out_last, frm_len, busy,
    input  err_len, err_cksum, err_tmo, err_ovr
  );

  // Frame controller side.
  modport slave (
    input  rx_data, done_flag, out_ready,
    output out_valid, out_data, out_last, frm_len, busy,
    output err_len, err_cksum, err_tmo, err_ovr
  );

endinterface

// File: rtl/uart_rx_frame_ctrl_buf.sv
// Payload buffer: DEPTH x 8 registers, synchronous write, combinational read, no reset.
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 5
) (
  input  logic          sclk_100M,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH];

  // Write the addressed entry; addresses are compared at full width so no index truncation occurs.
  always_ff @(posedge sclk_100M) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (i_we && (i_waddr == AW'(i))) begin
        r_mem[i] <= i_wdata;
      end
    end
  end

  // Combinational read mux; out-of-range addresses read as zero.
  always_comb begin
    o_rdata = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_raddr == AW'(i)) begin
        o_rdata = r_mem[i];
      end
    end
  end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frames uart_rx bytes (SOF, LEN, payload, XOR checksum), buffers the payload and
// releases it as a valid/ready stream only once the checksum has been verified.
module uart_rx_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter logic [7:0] SOF_BYTE    = SOF_DEFAULT,
  parameter int         MAX_LEN     = 16,
  parameter int         LEN_W       = 5,
  parameter int         TIMEOUT_CYC = 100000
) (
  input  logic                sclk_100M,
  input  logic                s_rst,
  uart_rx_frame_ctrl_if.slave bus
);

  localparam int               TMO_W     = $clog2(TIMEOUT_CYC);
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);

  frame_state_t     r_state, w_state_next;
  logic [LEN_W-1:0] r_len, w_len_next;
  logic [7:0]       r_cksum, w_cksum_next;
  logic [LEN_W-1:0] r_wr_ptr, w_wr_ptr_next;
  logic [LEN_W-1:0] r_rd_ptr, w_rd_ptr_next;
  logic [TMO_W-1:0] r_tmo_cnt, w_tmo_cnt_next;
  logic             r_out_valid, w_out_valid_next;
  logic             r_err_len, w_err_len_next;
  logic             r_err_cksum, w_err_cksum_next;
  logic             r_err_tmo, w_err_tmo_next;
  logic             r_err_ovr, w_err_ovr_next;

  logic             w_buf_we;
  logic [7:0]       w_rdata;
  logic [LEN_W-1:0] w_len_m1;
  logic             w_rd_last;
  logic             w_timed;
  logic [TMO_W-1:0] w_tmo_inc;
  logic             w_tmo_expire;

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (LEN_W)
  ) u_buf (
    .sclk_100M (sclk_100M),
    .i_we      (w_buf_we),
    .i_waddr   (r_wr_ptr),
    .i_wdata   (bus.rx_data),
    .i_raddr   (r_rd_ptr),
    .o_rdata   (w_rdata)
  );

  assign w_len_m1  = r_len - LEN_W'(1);
  assign w_rd_last = (r_rd_ptr == w_len_m1);
  assign w_timed   = (r_state == LEN) || (r_state == PAYLOAD) || (r_state == CKSUM);
  assign w_tmo_inc = r_tmo_cnt + TMO_W'(1);
  // Expiry is the edge on which the idle count reaches TIMEOUT_CYC-1; a byte on that edge wins.
  assign w_tmo_expire = w_timed && !bus.done_flag && (w_tmo_inc == TMO_LAST);

  // Next-state, datapath and error-pulse decode; at most one error can fire per cycle.
  always_comb begin
    w_state_next     = r_state;
    w_len_next       = r_len;
    w_cksum_next     = r_cksum;
    w_wr_ptr_next    = r_wr_ptr;
    w_rd_ptr_next    = r_rd_ptr;
    w_out_valid_next = r_out_valid;
    w_err_len_next   = 1'b0;
    w_err_cksum_next = 1'b0;
    w_err_tmo_next   = 1'b0;
    w_err_ovr_next   = 1'b0;
    w_buf_we         = 1'b0;
    w_tmo_cnt_next   = '0;

    if (w_timed && !bus.done_flag) begin
      w_tmo_cnt_next = w_tmo_inc;
    end

    if (w_tmo_expire) begin
      w_state_next   = IDLE;
      w_err_tmo_next = 1'b1;
      w_tmo_cnt_next = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.done_flag && (bus.rx_data == SOF_BYTE)) begin
            w_state_next = LEN;
          end
        end
        LEN: begin
          if (bus.done_flag) begin
            // Range check on the full byte so lengths above 2**LEN_W are not aliased.
            if ((bus.rx_data == 8'd0) || (bus.rx_data > MAX_LEN_B)) begin
              w_err_len_next = 1'b1;
              w_state_next   = IDLE;
            end else begin
              w_len_next    = bus.rx_data[LEN_W-1:0];
              w_cksum_next  = bus.rx_data;
              w_wr_ptr_next = '0;
              w_state_next  = PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (bus.done_flag) begin
            w_buf_we      = 1'b1;
            w_cksum_next  = cksum_next(r_cksum, bus.rx_data);
            w_wr_ptr_next = r_wr_ptr + LEN_W'(1);
            if (r_wr_ptr == w_len_m1) begin
              w_state_next = CKSUM;
            end
          end
        end
        CKSUM: begin
          if (bus.done_flag) begin
            if (bus.rx_data == r_cksum) begin
              w_state_next     = DRAIN;
              w_rd_ptr_next    = '0;
              w_out_valid_next = 1'b1;
            end else begin
              w_err_cksum_next = 1'b1;
              w_state_next     = IDLE;
            end
          end
        end
        DRAIN: begin
          if (r_out_valid && bus.out_ready) begin
            if (w_rd_last) begin
              w_state_next     = IDLE;
              w_out_valid_next = 1'b0;
            end else begin
              w_rd_ptr_next = r_rd_ptr + LEN_W'(1);
            end
          end
          // No room to parse while draining: the byte is dropped and flagged.
          if (bus.done_flag) begin
            w_err_ovr_next = 1'b1;
          end
        end
        default: begin
          w_state_next = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset; reset abandons any frame silently.
  always_ff @(posedge sclk_100M) begin
    if (s_rst) begin
      r_state     <= IDLE;
      r_len       <= '0;
      r_cksum     <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_tmo_cnt   <= '0;
      r_out_valid <= 1'b0;
      r_err_len   <= 1'b0;
      r_err_cksum <= 1'b0;
      r_err_tmo   <= 1'b0;
      r_err_ovr   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_len       <= w_len_next;
      r_cksum     <= w_cksum_next;
      r_wr_ptr    <= w_wr_ptr_next;
      r_rd_ptr    <= w_rd_ptr_next;
      r_tmo_cnt   <= w_tmo_cnt_next;
      r_out_valid <= w_out_valid_next;
      r_err_len   <= w_err_len_next;
      r_err_cksum <= w_err_cksum_next;
      r_err_tmo   <= w_err_tmo_next;
      r_err_ovr   <= w_err_ovr_next;
    end
  end

  // Stream fields are forced to zero outside a drain so reset shows all-zero outputs.
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_valid ? w_rdata : 8'h00;
  assign bus.out_last  = r_out_valid && w_rd_last;
  assign bus.frm_len   = r_out_valid ? r_len : '0;
  assign bus.busy      = (r_state != IDLE);
  assign bus.err_len   = r_err_len;
  assign bus.err_cksum = r_err_cksum;
  assign bus.err_tmo   = r_err_tmo;
  assign bus.err_ovr   = r_err_ovr;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Scoreboard bench for uart_rx_frame_ctrl: stimulus pushes expected bytes/errors, a monitor pops and compares.
module tb_uart_rx_frame_ctrl;

  localparam int MAX_LEN = 16;
  localparam int LEN_W   = 5;
  localparam int T       = 40;

  localparam int K_LEN   = 0;
  localparam int K_CKSUM = 1;
  localparam int K_TMO   = 2;
  localparam int K_OVR   = 3;

  typedef struct {
    logic [7:0]       data;
    logic             last;
    logic [LEN_W-1:0] len;
  } exp_byte_t;

  typedef struct {
    int kind;
    int cyc;
  } exp_err_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   rdy_mode = 1;

  exp_byte_t  exp_q[$];
  exp_err_t   err_q[$];
  logic [7:0] pl[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_frame_ctrl_if #(.LEN_W(LEN_W)) bus ();

  uart_rx_frame_ctrl #(
    .SOF_BYTE    (8'hA5),
    .MAX_LEN     (MAX_LEN),
    .LEN_W       (LEN_W),
    .TIMEOUT_CYC (T)
  ) dut (
    .sclk_100M (clk),
    .s_rst     (rst),
    .bus       (bus.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end else begin
      $display("ok   %s value=%0h (cycle %0d)", name, act, cyc);
    end
  endtask

  function automatic logic [19:0] outs_vec();
    return {bus.out_valid, bus.out_data, bus.out_last, bus.frm_len, bus.busy,
            bus.err_len, bus.err_cksum, bus.err_tmo, bus.err_ovr};
  endfunction

  // Reference checksum: XOR of the length byte with every payload byte.
  function automatic logic [7:0] frame_xor(input logic [7:0] len_b);
    logic [7:0] x;
    x = len_b;
    foreach (pl[i]) x = x ^ pl[i];
    return x;
  endfunction

  task automatic send_byte(input logic [7:0] b, output int s);
    @(posedge clk); #1;
    bus.rx_data   = b;
    bus.done_flag = 1'b1;
    @(posedge clk); #1;
    bus.done_flag = 1'b0;
    s = cyc;
  endtask

  // Sends one frame and records the expected outcome from the framing rules.
  task automatic send_frame(input logic [7:0] len_b, input logic [7:0] ck, input int gap, output int s);
    exp_byte_t e;
    exp_err_t  er;
    send_byte(8'hA5, s);
    send_byte(len_b, s);
    if (len_b == 8'd0 || int'(len_b) > MAX_LEN) begin
      er.kind = K_LEN; er.cyc = s; err_q.push_back(er);
      return;
    end
    for (int i = 0; i < int'(len_b); i++) begin
      repeat (gap) @(posedge clk);
      send_byte(pl[i], s);
    end
    send_byte(ck, s);
    if (ck == frame_xor(len_b)) begin
      for (int i = 0; i < int'(len_b); i++) begin
        e.data = pl[i];
        e.last = (i == int'(len_b) - 1);
        e.len  = LEN_W'(len_b);
        exp_q.push_back(e);
      end
    end else begin
      er.kind = K_CKSUM; er.cyc = s; err_q.push_back(er);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((bus.busy || exp_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check("wait_idle_bound", 32'(n), 32'(0));
  endtask

  task automatic set_pl(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    pl.delete();
    pl.push_back(a); pl.push_back(b); pl.push_back(c); pl.push_back(d);
  endtask

  // out_ready driver: held low, held high, or random backpressure.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 2) bus.out_ready = 1'($urandom_range(0, 1));
      else bus.out_ready = (rdy_mode == 1);
    end
  end

  // Monitor: pops expectations on transfers and error pulses, checks hold-while-stalled.
  initial begin
    logic        prev_stall;
    logic        last_seen;
    logic [7:0]  prev_data;
    logic        prev_last;
    logic [LEN_W-1:0] prev_len;
    exp_byte_t   e;
    exp_err_t    er;
    logic [3:0]  errs;
    prev_stall = 1'b0;
    last_seen  = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    prev_len   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        last_seen  = 1'b0;
      end else begin
        if (last_seen) begin
          check("busy_valid_after_last", {30'd0, bus.busy, bus.out_valid}, 32'd0);
          last_seen = 1'b0;
        end
        if (prev_stall) begin
          check("stall_hold", {bus.out_valid, bus.out_data, bus.out_last, bus.frm_len},
                {1'b1, prev_data, prev_last, prev_len});
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_out actual=%0h required=none", bus.out_data);
          end else begin
            e = exp_q.pop_front();
            check("out_byte", {bus.out_data, bus.out_last, bus.frm_len}, {e.data, e.last, e.len});
            if (bus.out_last) last_seen = 1'b1;
          end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_data  = bus.out_data;
        prev_last  = bus.out_last;
        prev_len   = bus.frm_len;
        errs = {bus.err_ovr, bus.err_tmo, bus.err_cksum, bus.err_len};
        if ($countones(errs) > 1) check("one_err_per_cycle", 32'(errs), 32'(0));
        for (int k = 0; k < 4; k++) begin
          if (errs[k]) begin
            if (err_q.size() == 0) begin
              checks++; failures++;
              $display("FAIL unexpected_err actual=kind%0d required=none", k);
            end else begin
              er = err_q.pop_front();
              check("err_kind_cycle", 32'(k * 65536 + cyc), 32'(er.kind * 65536 + er.cyc));
            end
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, s2;
    int sa;
    logic [7:0] len_b, ck, b;
    exp_err_t er;
    exp_byte_t e;
    bus.rx_data   = 8'h00;
    bus.done_flag = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", 32'(outs_vec()), 32'd0);

    // 1: basic frame with full throughput
    rdy_mode = 1;
    pl.delete(); pl.push_back(8'h11); pl.push_back(8'h22); pl.push_back(8'h33);
    send_frame(8'h03, 8'h03, 0, s);
    @(negedge clk);
    check("first_valid_latency", {31'd0, bus.out_valid}, 32'd1);
    wait_idle();

    // 2: bad checksum, then a good frame
    send_frame(8'h03, 8'h04, 0, s);
    @(negedge clk);
    check("cksum_no_valid", {30'd0, bus.out_valid, bus.busy}, 32'd0);
    send_frame(8'h03, 8'h03, 1, s);
    wait_idle();

    // 3: zero and oversize lengths
    send_frame(8'h00, 8'h00, 0, s);
    send_frame(8'h11, 8'h00, 0, s);
    wait_idle();

    // 4: timeout after AA, then a byte landing exactly on the expiry edge
    send_byte(8'hA5, s); send_byte(8'h02, s); send_byte(8'hAA, sa);
    er.kind = K_TMO; er.cyc = sa + T - 1; err_q.push_back(er);
    repeat (T + 2) @(posedge clk);
    @(negedge clk);
    check("busy_after_tmo", {31'd0, bus.busy}, 32'd0);
    send_byte(8'hA5, s); send_byte(8'h02, s); send_byte(8'hAA, sa);
    repeat (T - 3) @(posedge clk);
    send_byte(8'hBB, s2);
    check("expiry_edge_alignment", 32'(s2 - sa), 32'(T - 1));
    send_byte(8'h02 ^ 8'hAA ^ 8'hBB, s);
    e.len = LEN_W'(2);
    e.data = 8'hAA; e.last = 1'b0; exp_q.push_back(e);
    e.data = 8'hBB; e.last = 1'b1; exp_q.push_back(e);
    wait_idle();

    // 5: overrun while stalled, then lossless drain
    rdy_mode = 0;
    set_pl(8'hC1, 8'hC2, 8'hC3, 8'hC4);
    send_frame(8'h04, frame_xor(8'h04), 0, s);
    send_byte(8'h5C, s); er.kind = K_OVR; er.cyc = s; err_q.push_back(er);
    send_byte(8'hA5, s); er.kind = K_OVR; er.cyc = s; err_q.push_back(er);
    repeat (44) @(posedge clk);
    @(negedge clk);
    check("stalled_first_byte", {23'd0, bus.out_valid, bus.out_data}, {23'd0, 1'b1, 8'hC1});
    rdy_mode = 1;
    wait_idle();

    // 6: reset mid-payload and mid-drain, leading garbage ignored
    send_byte(8'hA5, s); send_byte(8'h05, s); send_byte(8'h01, s); send_byte(8'h02, s);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("reset_mid_payload", 32'(outs_vec()), 32'd0);
    rdy_mode = 0;
    set_pl(8'h10, 8'h20, 8'h30, 8'h40);
    send_frame(8'h04, frame_xor(8'h04), 0, s);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("reset_mid_drain", 32'(outs_vec()), 32'd0);
    rdy_mode = 1;
    send_byte(8'h00, s); send_byte(8'hFF, s);
    set_pl(8'h9A, 8'hBC, 8'hDE, 8'hF0);
    send_frame(8'h04, frame_xor(8'h04), 0, s);
    wait_idle();

    // 7: randomized frames with random backpressure
    rdy_mode = 2;
    for (int f = 0; f < 30; f++) begin
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h5A;
        send_byte(b, s);
      end
      if ($urandom_range(0, 9) == 0) begin
        len_b = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255));
      end else begin
        len_b = 8'($urandom_range(1, MAX_LEN));
      end
      pl.delete();
      for (int i = 0; i < MAX_LEN; i++) pl.push_back(8'($urandom_range(0, 255)));
      while (pl.size() > int'(len_b)) void'(pl.pop_back());
      ck = frame_xor(len_b);
      if ($urandom_range(0, 3) == 0) ck = ck ^ 8'($urandom_range(1, 255));
      send_frame(len_b, ck, int'($urandom_range(0, 3)), s);
      wait_idle();
    end

    repeat (5) @(posedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("err_q_drained", 32'(err_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
